rgb_slice_writer: RTL and testbench

- Upstream neighbour of the framebuffer.
- Receives the SBC's parallel RGB565 pixel stream and writes whole slices of 40x48 voxels into the slice RAM ring (SLICES_IN_RAM slices, starting at RAM_BASE).
- Tells the framebuffer when enough slices are buffered to start streaming (stream_ready).
- Reports each completed slice and any malformed frame.

---
 rtl/spirose_pkg.sv | 21 ++
 rtl/rise_detect.sv | 33 +++
 rtl/rgb_slice_writer.sv | 155 +++++++++++++++
 tb/tb_rgb_slice_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spirose_pkg.sv
// spirose_pkg
//   Definitions shared by the SBC-facing blocks of the voxel display:
//   slice geometry, RGB565 field offsets (also used by the framebuffer's
//   colour base) and the slice writer state encoding.
package spirose_pkg;

  localparam int ROW_SIZE    = 40;
  localparam int COLUMN_SIZE = 48;
  localparam int IMAGE_SIZE  = ROW_SIZE * COLUMN_SIZE;

  localparam int RGB_BLUE_LSB  = 0;
  localparam int RGB_GREEN_LSB = 5;
  localparam int RGB_RED_LSB   = 11;

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    ACTIVE,
    FRAME_DONE
  } slice_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Registers a level signal and flags its rising edge (previous registered
//   value 0, current registered value 1).
// Ports:
//   clk_33 - clock
//   nrst   - asynchronous active-low reset
//   sig    - level input, already synchronous to clk_33
//   rise   - high for one cycle per rising edge of the registered copy
module rise_detect (
  input  logic clk_33,
  input  logic nrst,
  input  logic sig,
  output logic rise
);

  logic cur;
  logic prev;

  // Two-stage history of the input; the edge is derived from registered
  // values only so every consumer sees the same, glitch-free pulse.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= sig;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/rgb_slice_writer.sv
// rgb_slice_writer
//   Takes the SBC's parallel RGB565 pixel stream and writes whole 40x48
//   slices into the slice RAM ring. Each vsync-delimited frame carries
//   SLICES_PER_FRAME slices; a frame cut short by an early vsync reports
//   frame_error and abandons its partial slice.
// Ports:
//   clk_33, nrst        - clock, asynchronous active-low reset
//   rgb_data/de/vsync   - SBC pixel bus (vsync active high)
//   ram_addr/wdata/we   - RAM write port, one word per cycle, 1-cycle latency
//   stream_ready        - sticky, READY_THRESHOLD slices have been completed
//   slice_done          - pulse coincident with the write of a slice's last pixel
//   write_slice         - ring index of the slice being filled
//   frame_error         - pulse on a malformed (short) frame
module rgb_slice_writer
  import spirose_pkg::*;
#(
  parameter int                        RAM_ADDR_WIDTH   = 32,
  parameter int                        RAM_DATA_WIDTH   = 16,
  parameter logic [RAM_ADDR_WIDTH-1:0] RAM_BASE         = '0,
  parameter int                        SLICES_IN_RAM    = 18,
  parameter int                        IMAGE_SIZE       = spirose_pkg::IMAGE_SIZE,
  parameter int                        SLICES_PER_FRAME = 6,
  parameter int                        READY_THRESHOLD  = 6
) (
  input  logic                             clk_33,
  input  logic                             nrst,
  input  logic [15:0]                      rgb_data,
  input  logic                             rgb_de,
  input  logic                             rgb_vsync,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]        ram_wdata,
  output logic                             ram_we,
  output logic                             stream_ready,
  output logic                             slice_done,
  output logic [$clog2(SLICES_IN_RAM)-1:0] write_slice,
  output logic                             frame_error
);

  localparam int PIX_W   = $clog2(IMAGE_SIZE);
  localparam int SLICE_W = $clog2(SLICES_IN_RAM);
  localparam int SIF_W   = $clog2(SLICES_PER_FRAME + 1);
  localparam int DONE_W  = $clog2(READY_THRESHOLD + 1);

  localparam logic [PIX_W-1:0]          LAST_PIX     = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [SLICE_W-1:0]        LAST_SLICE   = SLICE_W'(SLICES_IN_RAM - 1);
  localparam logic [SIF_W-1:0]          FRAME_SLICES = SIF_W'(SLICES_PER_FRAME);
  localparam logic [DONE_W-1:0]         DONE_MAX     = DONE_W'(READY_THRESHOLD);
  localparam logic [RAM_ADDR_WIDTH-1:0] SLICE_STEP   = RAM_ADDR_WIDTH'(IMAGE_SIZE);

  slice_state_t                state;
  logic [PIX_W-1:0]            pix_cnt;
  logic [SIF_W-1:0]            slice_in_frame;
  logic [DONE_W-1:0]           done_cnt;
  logic [RAM_ADDR_WIDTH-1:0]   slice_base;
  logic                        vsync_rise;

  logic                        pix_fire;
  logic                        slice_last;
  logic [PIX_W-1:0]            pix_next;
  logic [SIF_W-1:0]            sif_next;
  logic                        frame_full;

  rise_detect u_vsync_rise (
    .clk_33 (clk_33),
    .nrst   (nrst),
    .sig    (rgb_vsync),
    .rise   (vsync_rise)
  );

  // Counter values after this cycle's pixel (if any). The vsync handling
  // looks at these so a final pixel arriving together with vsync completes
  // its slice before the new frame is judged.
  always_comb begin
    pix_fire   = (state == ACTIVE) && rgb_de;
    slice_last = pix_fire && (pix_cnt == LAST_PIX);
    pix_next   = pix_cnt;
    if (slice_last) begin
      pix_next = '0;
    end else if (pix_fire) begin
      pix_next = pix_cnt + PIX_W'(1);
    end
    sif_next   = slice_in_frame + SIF_W'(slice_last);
    frame_full = (sif_next == FRAME_SLICES);
  end

  // Frame FSM, counters, slice base accumulator and registered RAM port.
  // A frame can only become full on a slice's last pixel, which leaves
  // pix_next at zero, so "not full" is exactly the short-frame condition.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state          <= WAIT_VSYNC;
      pix_cnt        <= '0;
      slice_in_frame <= '0;
      done_cnt       <= '0;
      slice_base     <= RAM_BASE;
      ram_addr       <= RAM_BASE;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      stream_ready   <= 1'b0;
      slice_done     <= 1'b0;
      write_slice    <= '0;
      frame_error    <= 1'b0;
    end else begin
      ram_we      <= 1'b0;
      slice_done  <= 1'b0;
      frame_error <= 1'b0;

      if (done_cnt == DONE_MAX) begin
        stream_ready <= 1'b1;
      end

      case (state)
        ACTIVE: begin
          if (pix_fire) begin
            ram_we    <= 1'b1;
            ram_wdata <= RAM_DATA_WIDTH'(rgb_data);
            ram_addr  <= slice_base + RAM_ADDR_WIDTH'(pix_cnt);
          end
          if (slice_last) begin
            slice_done <= 1'b1;
            if (write_slice == LAST_SLICE) begin
              write_slice <= '0;
              slice_base  <= RAM_BASE;
            end else begin
              write_slice <= write_slice + SLICE_W'(1);
              slice_base  <= slice_base + SLICE_STEP;
            end
            if (done_cnt != DONE_MAX) begin
              done_cnt <= done_cnt + DONE_W'(1);
            end
          end
          if (vsync_rise) begin
            pix_cnt        <= '0;
            slice_in_frame <= '0;
            frame_error    <= !frame_full;
          end else begin
            pix_cnt        <= pix_next;
            slice_in_frame <= sif_next;
            if (frame_full) begin
              state <= FRAME_DONE;
            end
          end
        end
        default: begin
          if (vsync_rise) begin
            state          <= ACTIVE;
            pix_cnt        <= '0;
            slice_in_frame <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_slice_writer.sv
// tb_rgb_slice_writer
//   Self-checking bench for rgb_slice_writer. A frame-level reference model
//   (pixel offset within the frame, frame start slice) predicts every
//   output each cycle; a table of stimulus segments adds end-of-segment
//   checks, and hand-written sequences cover vsync coinciding with a
//   slice's last pixel and reset in the middle of a slice.
module tb_rgb_slice_writer;

  localparam int          IMG       = 1920;
  localparam int          SLICES    = 18;
  localparam int          SPF       = 6;
  localparam int          THRESH    = 6;
  localparam int          FRAME_PIX = IMG * SPF;
  localparam logic [31:0] BASE      = 32'd0;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DONE   = 2;

  logic        clk_33;
  logic        nrst;
  logic [15:0] rgb_data;
  logic        rgb_de;
  logic        rgb_vsync;
  logic [31:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        stream_ready;
  logic        slice_done;
  logic [4:0]  write_slice;
  logic        frame_error;

  int checks;
  int errors;
  int err_seen;

  int          m_mode;
  int          m_frame_start;
  int          m_pix;
  int          m_completed;
  bit          m_vs_d1;
  bit          m_vs_d2;
  logic        exp_we;
  logic        exp_done;
  logic        exp_err;
  logic        exp_ready;
  logic [4:0]  exp_ws;
  logic [31:0] exp_addr;
  logic [15:0] exp_data;

  typedef struct {
    string name;
    bit    vsync_first;
    int    n_pix;
    int    de_pct;
    bit    index_data;
    int    exp_ws;
    bit    exp_ready;
    int    exp_err_total;
  } seg_t;

  seg_t segs[7];

  rgb_slice_writer dut (
    .clk_33       (clk_33),
    .nrst         (nrst),
    .rgb_data     (rgb_data),
    .rgb_de       (rgb_de),
    .rgb_vsync    (rgb_vsync),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .stream_ready (stream_ready),
    .slice_done   (slice_done),
    .write_slice  (write_slice),
    .frame_error  (frame_error)
  );

  initial clk_33 = 1'b0;
  always #15 clk_33 = ~clk_33;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int curSlice();
    return (m_frame_start + m_pix / IMG) % SLICES;
  endfunction

  task automatic modelReset();
    m_mode        = M_IDLE;
    m_frame_start = 0;
    m_pix         = 0;
    m_completed   = 0;
    m_vs_d1       = 1'b0;
    m_vs_d2       = 1'b0;
    exp_we        = 1'b0;
    exp_done      = 1'b0;
    exp_err       = 1'b0;
    exp_ready     = 1'b0;
    exp_ws        = 5'd0;
    exp_addr      = BASE;
    exp_data      = 16'd0;
  endtask

  // One clock of the reference: outputs visible after the edge that sampled
  // these inputs. The frame start edge is the registered vsync rising edge.
  task automatic modelStep(input bit vs, input bit de, input logic [15:0] data);
    bit edge_seen;
    edge_seen = m_vs_d1 && !m_vs_d2;
    m_vs_d2   = m_vs_d1;
    m_vs_d1   = vs;
    exp_ready = (m_completed >= THRESH);
    exp_we    = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    if (m_mode == M_ACTIVE && de) begin
      exp_we   = 1'b1;
      exp_data = data;
      exp_addr = BASE + 32'(curSlice() * IMG + m_pix % IMG);
      m_pix++;
      if (m_pix % IMG == 0) begin
        exp_done = 1'b1;
        m_completed++;
        if (m_pix == FRAME_PIX) m_mode = M_DONE;
      end
    end
    if (edge_seen) begin
      if (m_mode == M_ACTIVE) exp_err = 1'b1;
      if (m_mode != M_IDLE) m_frame_start = curSlice();
      m_mode = M_ACTIVE;
      m_pix  = 0;
    end
    exp_ws = 5'(curSlice());
  endtask

  task automatic checkOutput();
    check("ctrl{we,done,err,ready,ws}",
          {ram_we, slice_done, frame_error, stream_ready, write_slice},
          {exp_we, exp_done, exp_err, exp_ready, exp_ws});
    if (exp_we) check("write{addr,data}", {ram_addr, ram_wdata}, {exp_addr, exp_data});
    if (frame_error === 1'b1) err_seen++;
  endtask

  task automatic applyStimulus(input bit vs, input bit de, input logic [15:0] data);
    @(negedge clk_33);
    rgb_vsync = vs;
    rgb_de    = de;
    rgb_data  = data;
    @(posedge clk_33);
    modelStep(vs, de, data);
    #1;
    checkOutput();
  endtask

  task automatic vsyncPulse();
    applyStimulus(1'b1, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic feedPixels(input int n, input int pct, input bit index_data);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) >= pct) applyStimulus(1'b0, 1'b0, 16'($urandom));
      applyStimulus(1'b0, 1'b1, index_data ? 16'(i) : 16'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic doReset(input string name);
    @(negedge clk_33);
    nrst      = 1'b0;
    rgb_vsync = 1'b0;
    rgb_de    = 1'b0;
    rgb_data  = 16'd0;
    #1;
    check(name, {ram_addr, ram_wdata, ram_we, stream_ready, slice_done, write_slice, frame_error},
          {BASE, 16'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
    modelReset();
    @(negedge clk_33);
    nrst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    err_seen  = 0;
    nrst      = 1'b0;
    rgb_vsync = 1'b0;
    rgb_de    = 1'b0;
    rgb_data  = 16'd0;
    modelReset();

    segs[0] = '{"pixel write",     1'b1, IMG,         100, 1'b1, 1,  1'b0, 0};
    segs[1] = '{"ready threshold", 1'b0, 5 * IMG,     90,  1'b0, 6,  1'b1, 0};
    segs[2] = '{"extra pixels",    1'b0, 50,          100, 1'b0, 6,  1'b1, 0};
    segs[3] = '{"second frame",    1'b1, FRAME_PIX,   100, 1'b0, 12, 1'b1, 0};
    segs[4] = '{"ring wrap",       1'b1, FRAME_PIX,   100, 1'b0, 0,  1'b1, 0};
    segs[5] = '{"short frame",     1'b1, 2 * IMG + 100, 75, 1'b0, 2, 1'b1, 0};
    segs[6] = '{"early vsync",     1'b1, 1,           100, 1'b0, 2,  1'b1, 1};

    repeat (2) @(posedge clk_33);
    doReset("reset values");

    for (int s = 0; s < 7; s++) begin
      $display("[TB] segment: %s", segs[s].name);
      if (segs[s].vsync_first) vsyncPulse();
      feedPixels(segs[s].n_pix, segs[s].de_pct, segs[s].index_data);
      idle(2);
      check({segs[s].name, " write_slice"}, 64'(write_slice), 64'(segs[s].exp_ws));
      check({segs[s].name, " stream_ready"}, 64'(stream_ready), 64'(segs[s].exp_ready));
      check({segs[s].name, " frame_error count"}, 64'(err_seen), 64'(segs[s].exp_err_total));
    end

    $display("[TB] vsync with last pixel of a short frame");
    feedPixels(IMG - 2, 100, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b1, 16'($urandom));
    idle(2);
    check("short coincident write_slice", 64'(write_slice), 64'd3);
    check("short coincident frame_error count", 64'(err_seen), 64'd2);

    $display("[TB] vsync with last pixel of a full frame");
    feedPixels(FRAME_PIX - 1, 100, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b1, 16'($urandom));
    idle(2);
    check("full coincident write_slice", 64'(write_slice), 64'd9);
    check("full coincident frame_error count", 64'(err_seen), 64'd2);

    $display("[TB] reset mid-slice");
    feedPixels(500, 100, 1'b0);
    doReset("mid-slice reset values");
    vsyncPulse();
    applyStimulus(1'b0, 1'b1, 16'h1234);
    check("restart write{we,addr}", {ram_we, ram_addr}, {1'b1, BASE});
    idle(2);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
